writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter WIDTH, 24, scalar/element data width.
REQ-002 Parameter VECTOR_WIDTH, 8, elements per vector register.
REQ-003 Parameter ADDRESSWIDTH, 4, register address width.
REQ-004 One clock; reset is synchronous and active-high; ports SHALL be named clock and reset.
REQ-005 Ports (name direction width meaning) SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result present
- alu_ready  out  1  ALU result accepted this cycle
- alu_addr  in  ADDRESSWIDTH  destination register
- alu_data  in  WIDTH  scalar result / element value
- alu_data_v  in  VECTOR_WIDTH x WIDTH  vector result
- alu_isvector  in  1  destination is vector register
- alu_vect_esc  in  1  single-element vector write
- alu_index  in  3  element index for vect_esc
- mem_valid  in  1  load beat present
- mem_ready  out  1  load beat accepted this cycle
- mem_addr  in  ADDRESSWIDTH  load destination register
- mem_data  in  WIDTH  load beat data
- mem_isvector  in  1  beat belongs to 8-beat vector load
- writeEnable  out  1  register-file write strobe
- writeAddress  out  ADDRESSWIDTH  write destination
- dataToSave  out  WIDTH  scalar/element write data
- dataToSave_v  out  VECTOR_WIDTH x WIDTH  full vector write data
- isvector_A  out  1  write targets vector file
- vect_esc_A  out  1  write is single vector element
- index_A  out  3  element index for vect_esc_A
- busy  out  1  vector gather in progress

Function
REQ-006 A transfer SHALL occur on a channel when valid and ready are both high at a rising clock edge.
REQ-007 All write-port outputs SHALL be registered; an accepted transfer SHALL appear on writeEnable exactly 1 cycle after acceptance, held for one cycle.
REQ-008 At most one transfer SHALL be accepted per cycle; writeEnable SHALL be low in any cycle following a cycle with no transfer.
REQ-009 States SHALL be IDLE and GATHER; busy SHALL equal (state == GATHER).
REQ-010 IDLE: mem_ready=1; alu_ready = NOT mem_valid (memory has fixed priority).
REQ-011 IDLE, mem beat with mem_isvector=0: scalar write, dataToSave=mem_data, isvector_A=0, vect_esc_A=0.
REQ-012 IDLE, mem beat with mem_isvector=1: mem_data stored as element 0, element counter=1, gather address latched from mem_addr, no write issued, next state GATHER.
REQ-013 GATHER: mem_ready=1; each beat stores mem_data at element[counter], counter increments; mem_addr and mem_isvector ignored.
REQ-014 GATHER, beat at counter=7: output registers SHALL load the full vector (elements 0..6 plus mem_data at 7), isvector_A=1, vect_esc_A=0, writeAddress=gather address; counter wraps to 0; next state IDLE.
REQ-015 GATHER: alu_ready = NOT (mem_valid AND counter==7) AND NOT (alu_isvector AND alu_addr == gather address).
REQ-016 ALU transfer SHALL copy alu_addr, alu_data, alu_data_v, alu_isvector, alu_vect_esc, alu_index to the write-port outputs unchanged.
REQ-017 Unused data outputs (dataToSave_v on scalar writes, dataToSave on full vector writes) SHALL hold their previous values.

Reset
REQ-018 On reset: state IDLE, counter 0, gather buffer and all outputs 0, busy=0, writeEnable=0.
REQ-019 Reset during GATHER SHALL discard the partial vector; no write SHALL be issued for it.

Structure
REQ-020 WIDTH/VECTOR_WIDTH/ADDRESSWIDTH defaults, the state enum and the write-port struct SHALL live in shared package vector_pkg.
REQ-021 The 8-element gather buffer with counter SHALL be sub-module vector_gather_buffer.

Verification
REQ-022 ALU scalar addr 3, data 9 -> next cycle writeEnable=1, writeAddress=3, dataToSave=9, isvector_A=0.
REQ-023 mem_valid and alu_valid same cycle in IDLE (mem addr 2 data 5; ALU addr 6) -> alu_ready=0; write addr 2 data 5 first, ALU write addr 6 the cycle after.
REQ-024 8 vector beats to addr 4, data 2,3,4,8,4,6,1,2 -> busy=1 for 7 cycles, then single write: isvector_A=1, addr 4, element i = beat i.
REQ-025 ALU vect_esc addr 3, index 2, data 10 during gather to addr 4 -> accepted, write vect_esc_A=1, index_A=2; ALU vector write to addr 4 during gather -> alu_ready=0 until gather completes.
REQ-026 reset asserted after 5 vector beats -> busy=0 next cycle, no vector write; following scalar load writes normally.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared widths, state encoding and write-port record for the writeback path.
package vector_pkg;

  localparam int WIDTH        = 24;
  localparam int VECTOR_WIDTH = 8;
  localparam int ADDRESSWIDTH = 4;
  localparam int INDEXWIDTH   = 3;

  typedef enum logic {
    IDLE,
    GATHER
  } wb_state_e;

  typedef logic [VECTOR_WIDTH-1:0][WIDTH-1:0] vec_t;

  // One registered register-file write request.
  typedef struct packed {
    logic                    we;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [WIDTH-1:0]        data;
    vec_t                    data_v;
    logic                    isvector;
    logic                    vect_esc;
    logic [INDEXWIDTH-1:0]   index;
  } wb_port_t;

endpackage

// File: rtl/vector_gather_buffer.sv
// Collects vector-load beats one element at a time. fill_v shows the buffer
// contents including the beat being pushed this cycle, so the final beat can
// be written out together with the elements already stored.
module vector_gather_buffer #(
  parameter int WIDTH = vector_pkg::WIDTH,
  parameter int DEPTH = vector_pkg::VECTOR_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  output logic [$clog2(DEPTH)-1:0]         count,
  output logic                             last,
  output logic [DEPTH-1:0][WIDTH-1:0]      fill_v
);

  localparam int CW = $clog2(DEPTH);

  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0] elems_q, elems_d;

  // Next contents: write the pushed beat at the current slot and advance.
  always_comb begin
    elems_d = elems_q;
    count_d = count_q;
    if (push) begin
      elems_d[count_q] = push_data;
      count_d          = (count_q == CW'(DEPTH - 1)) ? '0 : count_q + 1'b1;
    end
  end

  // Element storage and slot counter.
  always_ff @(posedge clock) begin
    // NOTE: this storage is cleared on reset on purpose; a stale partial vector must never become observable after reset.
    if (reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      elems_q <= '0;
      count_q <= '0;
    end else begin
      elems_q <= elems_d;
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign last   = (count_q == CW'(DEPTH - 1));
  assign fill_v = elems_d;

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter. Memory beats have fixed priority over ALU
// results; 8-beat vector loads are gathered and written as one vector.
// The write-port record comes from vector_pkg, so the parameters are expected
// to keep their package default values.
module writeback_unit #(
  parameter int WIDTH        = vector_pkg::WIDTH,
  parameter int VECTOR_WIDTH = vector_pkg::VECTOR_WIDTH,
  parameter int ADDRESSWIDTH = vector_pkg::ADDRESSWIDTH
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 alu_valid,
  output logic                                 alu_ready,
  input  logic [ADDRESSWIDTH-1:0]              alu_addr,
  input  logic [WIDTH-1:0]                     alu_data,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   alu_data_v,
  input  logic                                 alu_isvector,
  input  logic                                 alu_vect_esc,
  input  logic [2:0]                           alu_index,
  input  logic                                 mem_valid,
  output logic                                 mem_ready,
  input  logic [ADDRESSWIDTH-1:0]              mem_addr,
  input  logic [WIDTH-1:0]                     mem_data,
  input  logic                                 mem_isvector,
  output logic                                 writeEnable,
  output logic [ADDRESSWIDTH-1:0]              writeAddress,
  output logic [WIDTH-1:0]                     dataToSave,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   dataToSave_v,
  output logic                                 isvector_A,
  output logic                                 vect_esc_A,
  output logic [2:0]                           index_A,
  output logic                                 busy
);

  import vector_pkg::*;

  wb_state_e                     state_q, state_d;
  wb_port_t                      out_q, out_d;
  logic [ADDRESSWIDTH-1:0]       gather_addr_q, gather_addr_d;
  logic                          push;
  logic                          last;
  logic [$clog2(VECTOR_WIDTH)-1:0] count;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] fill_v;

  vector_gather_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (VECTOR_WIDTH)
  ) u_gather (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (mem_data),
    .count     (count),
    .last      (last),
    .fill_v    (fill_v)
  );

  assign mem_ready = 1'b1;

  // Arbitration, gather sequencing and next write-port contents.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d       = state_q;
    gather_addr_d = gather_addr_q;
    out_d         = out_q;
    out_d.we      = 1'b0;
    push          = 1'b0;
    alu_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        alu_ready = !mem_valid;
        if (mem_valid) begin
          if (mem_isvector) begin
            push          = 1'b1;
            gather_addr_d = mem_addr;
            state_d       = GATHER;
          end else begin
            out_d.we       = 1'b1;
            out_d.addr     = mem_addr;
            out_d.data     = mem_data;
            out_d.isvector = 1'b0;
            out_d.vect_esc = 1'b0;
          end
        end
      end
      GATHER: begin
        // Block the ALU when the final beat claims the write port, or when it
        // would overwrite the vector register currently being assembled.
        alu_ready = !(mem_valid && last) &&
                    !(alu_isvector && (alu_addr == gather_addr_q));
        if (mem_valid) begin
          push = 1'b1;
          if (last) begin
            out_d.we       = 1'b1;
            out_d.addr     = gather_addr_q;
            out_d.data_v   = fill_v;
            out_d.isvector = 1'b1;
            out_d.vect_esc = 1'b0;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (alu_valid && alu_ready) begin
      out_d.we       = 1'b1;
      out_d.addr     = alu_addr;
      out_d.data     = alu_data;
      out_d.data_v   = alu_data_v;
      out_d.isvector = alu_isvector;
      out_d.vect_esc = alu_vect_esc;
      out_d.index    = alu_index;
    end
  end

  // State, gather address and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      gather_addr_q <= '0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      gather_addr_q <= gather_addr_d;
      out_q         <= out_d;
    end
  end

  assign writeEnable  = out_q.we;
  assign writeAddress = out_q.addr;
  assign dataToSave   = out_q.data;
  assign dataToSave_v = out_q.data_v;
  assign isvector_A   = out_q.isvector;
  assign vect_esc_A   = out_q.vect_esc;
  assign index_A      = out_q.index;
  assign busy         = (state_q == GATHER);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a write scoreboard.
module tb_writeback_unit;

  localparam int W  = 24;
  localparam int VW = 8;
  localparam int AW = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   alu_valid, alu_ready;
  logic [AW-1:0]          alu_addr;
  logic [W-1:0]           alu_data;
  logic [VW-1:0][W-1:0]   alu_data_v;
  logic                   alu_isvector, alu_vect_esc;
  logic [2:0]             alu_index;
  logic                   mem_valid, mem_ready;
  logic [AW-1:0]          mem_addr;
  logic [W-1:0]           mem_data;
  logic                   mem_isvector;
  logic                   writeEnable;
  logic [AW-1:0]          writeAddress;
  logic [W-1:0]           dataToSave;
  logic [VW-1:0][W-1:0]   dataToSave_v;
  logic                   isvector_A, vect_esc_A;
  logic [2:0]             index_A;
  logic                   busy;

  always #5 clock = ~clock;

  writeback_unit dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_data_v   (alu_data_v),
    .alu_isvector (alu_isvector),
    .alu_vect_esc (alu_vect_esc),
    .alu_index    (alu_index),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_isvector (mem_isvector),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .dataToSave   (dataToSave),
    .dataToSave_v (dataToSave_v),
    .isvector_A   (isvector_A),
    .vect_esc_A   (vect_esc_A),
    .index_A      (index_A),
    .busy         (busy)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [W-1:0]     data;
    logic [VW*W-1:0]  data_v;
    logic             isv;
    logic             esc;
    logic [2:0]       idx;
    logic             chk_idx;
  } exp_t;

  exp_t            sb[$];
  int              tests_run     = 0;
  int              tests_failed  = 0;
  int              writes_seen   = 0;
  int              writes_pushed = 0;
  logic [W-1:0]    exp_d_last    = '0;
  logic [VW*W-1:0] exp_v_last    = '0;
  int              busy_cycles;
  logic [VW-1:0][W-1:0] gv;
  logic [VW-1:0][W-1:0] alu_vec_pat;

  task automatic check(input string tag, input logic [VW*W-1:0] obs, input logic [VW*W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected write; tracks the last data values so held fields can be predicted.
  task automatic push_exp(input logic [AW-1:0] addr, input logic [W-1:0] data,
                          input logic [VW*W-1:0] data_v, input logic isv,
                          input logic esc, input logic [2:0] idx, input logic chk_idx);
    exp_t e;
    e.addr = addr; e.data = data; e.data_v = data_v;
    e.isv = isv; e.esc = esc; e.idx = idx; e.chk_idx = chk_idx;
    sb.push_back(e);
    exp_d_last = data;
    exp_v_last = data_v;
    writes_pushed++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (writeEnable) begin
      writes_seen++;
      if (sb.size() == 0) begin
        check("unexpected_write_count", 32'(writes_seen), 32'(writes_pushed));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr",     writeAddress, e.addr);
        check("wr_data",     dataToSave,   e.data);
        check("wr_data_v",   dataToSave_v, e.data_v);
        check("wr_isvector", isvector_A,   e.isv);
        check("wr_vect_esc", vect_esc_A,   e.esc);
        if (e.chk_idx) check("wr_index", index_A, e.idx);
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_addr = '0; alu_data = '0; alu_data_v = '0;
    alu_isvector = 0; alu_vect_esc = 0; alu_index = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0; mem_isvector = 0;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst_busy",   busy, 1'b0);
    check("rst_we",     writeEnable, 1'b0);
    check("rst_addr",   writeAddress, '0);
    check("rst_data",   dataToSave, '0);
    check("rst_data_v", dataToSave_v, '0);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_alu_ready", alu_ready, 1'b1);

    // ALU scalar write addr 3 data 9
    alu_valid = 1; alu_addr = 4'd3; alu_data = 24'd9; alu_data_v = exp_v_last;
    settle();
    check("alu_scalar_ready", alu_ready, 1'b1);
    push_exp(4'd3, 24'd9, exp_v_last, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    alu_valid = 0;

    // Memory wins over ALU in IDLE; ALU written the cycle after
    mem_valid = 1; mem_addr = 4'd2; mem_data = 24'd5; mem_isvector = 0;
    alu_valid = 1; alu_addr = 4'd6; alu_data = 24'd7; alu_data_v = exp_v_last;
    settle();
    check("prio_alu_ready", alu_ready, 1'b0);
    check("prio_mem_ready", mem_ready, 1'b1);
    push_exp(4'd2, 24'd5, exp_v_last, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    mem_valid = 0;
    settle();
    check("prio_alu_ready_after", alu_ready, 1'b1);
    push_exp(4'd6, 24'd7, exp_v_last, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    alu_valid = 0;
    tick();

    // 8-beat gather to addr 4 with ALU traffic alongside
    gv[0] = 24'd2; gv[1] = 24'd3; gv[2] = 24'd4; gv[3] = 24'd8;
    gv[4] = 24'd4; gv[5] = 24'd6; gv[6] = 24'd1; gv[7] = 24'd2;
    for (int i = 0; i < VW; i++) alu_vec_pat[i] = W'(32'h00A000 + i);
    busy_cycles = 0;
    for (int i = 0; i < VW; i++) begin
      if (busy) busy_cycles++;
      check($sformatf("gather_busy_%0d", i), busy, (i > 0));
      mem_valid = 1; mem_data = gv[i];
      mem_addr = (i == 0) ? 4'd4 : 4'd9;
      mem_isvector = (i == 0) ? 1'b1 : 1'(i % 2);
      alu_valid = 0;
      if (i == 2) begin
        alu_valid = 1; alu_addr = 4'd3; alu_index = 3'd2; alu_data = 24'd10;
        alu_isvector = 1; alu_vect_esc = 1; alu_data_v = exp_v_last;
      end
      if (i >= 4) begin
        alu_valid = 1; alu_addr = 4'd4; alu_isvector = 1; alu_vect_esc = 0;
        alu_index = 3'd0; alu_data_v = alu_vec_pat;
        if (i == 4) alu_data = exp_d_last;
      end
      settle();
      if (i == 2) begin
        check("vesc_alu_ready", alu_ready, 1'b1);
        push_exp(4'd3, 24'd10, exp_v_last, 1'b1, 1'b1, 3'd2, 1'b1);
      end
      if (i >= 4) check($sformatf("vec_block_ready_%0d", i), alu_ready, 1'b0);
      if (i == VW - 1) push_exp(4'd4, exp_d_last, gv, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
    end
    mem_valid = 0; mem_isvector = 0;
    settle();
    check("gather_busy_cycles", 32'(busy_cycles), 32'd7);
    check("gather_done_busy", busy, 1'b0);
    check("vec_alu_ready_after", alu_ready, 1'b1);
    push_exp(4'd4, exp_d_last, alu_vec_pat, 1'b1, 1'b0, 3'd0, 1'b1);
    tick();
    alu_valid = 0; alu_isvector = 0;
    tick();

    // Reset in the middle of a gather discards it
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1; mem_addr = 4'd5; mem_isvector = 1; mem_data = W'(32'h50 + i);
      tick();
    end
    mem_valid = 0; mem_isvector = 0;
    check("midgather_busy", busy, 1'b1);
    reset = 1;
    tick();
    reset = 0;
    settle();
    exp_d_last = '0; exp_v_last = '0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_we",   writeEnable, 1'b0);
    check("midrst_data", dataToSave, '0);

    // Scalar load after reset, then a fresh gather starting at element 0
    mem_valid = 1; mem_addr = 4'd7; mem_data = 24'h123456; mem_isvector = 0;
    settle();
    push_exp(4'd7, 24'h123456, exp_v_last, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    for (int i = 0; i < VW; i++) begin
      gv[i] = W'(32'h100 + 3 * i);
      mem_valid = 1; mem_addr = 4'd1; mem_isvector = 1; mem_data = gv[i];
      if (i == VW - 1) push_exp(4'd1, exp_d_last, gv, 1'b1, 1'b0, 3'd0, 1'b0);
      tick();
    end
    mem_valid = 0; mem_isvector = 0;
    tick(); tick(); tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("write_count", 32'(writes_seen), 32'(writes_pushed));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
